keypad_entry: RTL

Upstream front end of the calculator datapath. It collects single-key strobes from the keypad scanner: decimal digits for operand A, an operator key, then decimal digits for operand B. It assembles these into one 35-bit instruction word and hands it to the instruction decoder over a valid/ready handshake. Entry is blocked while an instruction is waiting to be accepted.

---
 rtl/keypad_entry.sv | 138 +++++++++++++
 1 files changed

// File: rtl/keypad_entry.sv
// Keypad entry front end: assembles operand A, operator and operand B from key strobes
// into one instruction word and offers it to the decoder over a valid/ready handshake.
module keypad_entry #(
  parameter int unsigned OPW = 16,
  parameter int unsigned FW  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic [2*OPW+FW-1:0]   instruction,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [OPW-1:0]        display,
  output logic                  overflow,
  output logic [1:0]            state
);

  localparam int unsigned AW = OPW + 4;
  localparam int unsigned IW = 2 * OPW + FW;

  typedef enum logic [1:0] {
    StEnterA = 2'd0,
    StEnterB = 2'd1,
    StIssue  = 2'd2
  } state_e;

  localparam logic [3:0] KeyClear = 4'd14;
  localparam logic [3:0] KeyEnter = 4'd15;

  state_e            state_q, state_d;
  logic [OPW-1:0]    acc_a_q, acc_a_d;
  logic [OPW-1:0]    acc_b_q, acc_b_d;
  logic [FW-1:0]     funct_q, funct_d;
  logic [IW-1:0]     instr_q, instr_d;
  logic              overflow_q, overflow_d;

  logic              is_digit;
  logic              is_op;
  logic [FW-1:0]     op_funct;
  logic [OPW-1:0]    acc_sel;
  logic [AW-1:0]     acc_ext;
  logic              digit_fits;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StEnterA;
      acc_a_q    <= '0;
      acc_b_q    <= '0;
      funct_q    <= '0;
      instr_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_a_q    <= acc_a_d;
      acc_b_q    <= acc_b_d;
      funct_q    <= funct_d;
      instr_q    <= instr_d;
      overflow_q <= overflow_d;
    end
  end

  // Candidate acc*10+digit for whichever operand is being entered, wide enough to see overflow.
  always_comb begin
    is_digit   = (key_code <= 4'd9);
    is_op      = (key_code >= 4'd10) && (key_code <= 4'd13);
    op_funct   = FW'(key_code - 4'd10);
    acc_sel    = (state_q == StEnterA) ? acc_a_q : acc_b_q;
    acc_ext    = AW'(acc_sel) * AW'(10) + AW'(key_code);
    digit_fits = (acc_ext[AW-1:OPW] == '0);
  end

  always_comb begin
    state_d    = state_q;
    acc_a_d    = acc_a_q;
    acc_b_d    = acc_b_q;
    funct_d    = funct_q;
    instr_d    = instr_q;
    overflow_d = overflow_q;

    unique case (state_q)
      StEnterA: begin
        if (key_valid) begin
          if (is_digit) begin
            if (digit_fits) acc_a_d = acc_ext[OPW-1:0];
            else            overflow_d = 1'b1;
          end else if (is_op) begin
            funct_d = op_funct;
            acc_b_d = '0;
            state_d = StEnterB;
          end else if (key_code == KeyClear) begin
            acc_a_d    = '0;
            overflow_d = 1'b0;
          end
        end
      end
      StEnterB: begin
        if (key_valid) begin
          if (is_digit) begin
            if (digit_fits) acc_b_d = acc_ext[OPW-1:0];
            else            overflow_d = 1'b1;
          end else if (is_op) begin
            funct_d = op_funct;
          end else if (key_code == KeyEnter) begin
            instr_d = {acc_a_q, acc_b_q, funct_q};
            state_d = StIssue;
          end else if (key_code == KeyClear) begin
            acc_a_d    = '0;
            acc_b_d    = '0;
            funct_d    = '0;
            overflow_d = 1'b0;
            state_d    = StEnterA;
          end
        end
      end
      StIssue: begin
        // Keys are ignored here; only the handshake leaves this state.
        if (instr_ready) begin
          acc_a_d    = '0;
          acc_b_d    = '0;
          funct_d    = '0;
          overflow_d = 1'b0;
          state_d    = StEnterA;
        end
      end
      default: state_d = StEnterA;
    endcase
  end

  always_comb begin
    instruction = instr_q;
    instr_valid = (state_q == StIssue);
    display     = (state_q == StEnterA) ? acc_a_q : acc_b_q;
    overflow    = overflow_q;
    state       = state_q;
  end

endmodule
